// File: rtl/mux_arb_pkg.sv
// Shared types and select encoding for the two-input packet arbiter and its downstream 2:1 mux.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/out_reg_stage.sv
// Single registered valid/payload stage; accepts a new word whenever empty or draining.
module out_reg_stage #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         out_ready,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         can_load
);

    assign can_load = !valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (out_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_arb_2.sv
// Round-robin packet arbiter for two valid/ready streams; exports se/en to the downstream mux.
module mux_arb_2
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    input  logic              y_ready,
    output logic              se,
    output logic              en,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    state_t            state;
    logic              ptr;
    logic [CNT_W-1:0]  cnt;

    logic              can_load;
    logic              g_ready;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              xfer;
    logic              at_max;
    logic              force_rel;
    logic              pkt_end;
    logic [DATA_W:0]   y_word;

    // Ready depends only on registered grant and the output stage's drain state.
    assign g_ready = en && can_load;
    assign a_ready = g_ready && (se == SEL_A);
    assign b_ready = g_ready && (se == SEL_B);

    // Only the granted channel reaches the datapath.
    assign g_valid = (se == SEL_B) ? b_valid : a_valid;
    assign g_last  = (se == SEL_B) ? b_last  : a_last;
    assign g_data  = (se == SEL_B) ? b_data  : a_data;

    assign xfer      = g_valid && g_ready;
    assign at_max    = (cnt == CNT_W'(MAX_BEATS - 1));
    assign force_rel = xfer && !g_last && at_max;
    assign pkt_end   = xfer && (g_last || at_max);

    out_reg_stage #(
        .W (DATA_W + 1)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (xfer),
        .d         ({g_last || at_max, g_data}),
        .out_ready (y_ready),
        .valid     (y_valid),
        .q         (y_word),
        .can_load  (can_load)
    );

    assign y_last = y_word[DATA_W];
    assign y_data = y_word[DATA_W-1:0];

    // Grant FSM with beat counter; a packet end or overrun hands priority to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= SEL_A;
            se    <= SEL_A;
            en    <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_valid && (!b_valid || ptr == SEL_A)) begin
                        state <= LOCK_A;
                        se    <= SEL_A;
                        en    <= 1'b1;
                    end else if (b_valid) begin
                        state <= LOCK_B;
                        se    <= SEL_B;
                        en    <= 1'b1;
                    end
                end
                LOCK_A, LOCK_B: begin
                    if (pkt_end) begin
                        state <= IDLE;
                        en    <= 1'b0;
                        ptr   <= ~se;
                        cnt   <= '0;
                        err   <= force_rel;
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arb_2.sv
// Directed bench for mux_arb_2: queue-driven sources, output log against hand-written expectations.
module tb_mux_arb_2;

    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BEATS = 4;

    logic          clk;
    logic          rst;
    logic          a_valid, a_last, a_ready;
    logic          b_valid, b_last, b_ready;
    logic [DW-1:0] a_data, b_data, y_data;
    logic          y_valid, y_last, y_ready;
    logic          se, en, err;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            bubbles = 0;
    int            err_cnt = 0;
    int            beat_n  = 0;
    logic          new_pkt = 1'b1;

    logic [DW:0]   a_q[$];
    logic [DW:0]   b_q[$];
    logic [DW:0]   out_q[$];
    logic [DW:0]   exp_q[$];
    logic          pkt_se[$];
    logic          exp_se[$];

    mux_arb_2 #(
        .DATA_W    (DW),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_ready (y_ready),
        .se      (se),
        .en      (en),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        a_valid = (a_q.size() != 0);
        b_valid = (b_q.size() != 0);
        {a_last, a_data} = a_valid ? a_q[0] : 9'h0;
        {b_last, b_data} = b_valid ? b_q[0] : 9'h0;
    endtask

    task automatic note_fire(input logic last);
        if (new_pkt) pkt_se.push_back(se);
        beat_n++;
        if (last || beat_n == int'(MAX_BEATS)) begin
            beat_n  = 0;
            new_pkt = 1'b1;
        end else begin
            new_pkt = 1'b0;
        end
    endtask

    // One clock: observe handshakes at negedge, check latency/hold after the edge, advance sources.
    task automatic step();
        logic          a_fire, b_fire, hold;
        logic [DW+1:0] held;
        logic [DW-1:0] ad, bd;
        @(negedge clk);
        a_fire = !rst && a_valid && a_ready;
        b_fire = !rst && b_valid && b_ready;
        ad = a_data;
        bd = b_data;
        if (!rst && !en) check("idle_ready", 32'({a_ready, b_ready}), 32'd0);
        if (en) check("ready_excl", 32'(a_ready & b_ready), 32'd0);
        if (!rst && y_valid && !y_ready) check("bp_ready", 32'({a_ready, b_ready}), 32'd0);
        if (!rst && y_valid && y_ready) out_q.push_back({y_last, y_data});
        if (err) begin
            err_cnt++;
            check("err_last", 32'(y_last), 32'd1);
        end
        if (!rst && !en && (a_q.size() != 0 || b_q.size() != 0)) bubbles++;
        if (a_fire) note_fire(a_last);
        if (b_fire) note_fire(b_last);
        held = {y_valid, y_last, y_data};
        hold = !rst && y_valid && !y_ready;
        @(posedge clk);
        #1;
        if (a_fire) check("lat_a", 32'({y_valid, y_data}), 32'({1'b1, ad}));
        if (b_fire) check("lat_b", 32'({y_valid, y_data}), 32'({1'b1, bd}));
        if (hold) check("hold", 32'({y_valid, y_last, y_data}), 32'(held));
        if (a_fire) void'(a_q.pop_front());
        if (b_fire) void'(b_q.pop_front());
        drive();
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (a_q.size() == 0 && b_q.size() == 0 && !y_valid && !en) done = 1'b1;
            else step();
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    task automatic wait_y(input logic [DW-1:0] d, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (y_valid && y_data == d) found = 1'b1;
        end
        check("wait_y", 32'(found), 32'd1);
    endtask

    task automatic cmp_logs();
        check("out_len", 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            check("out_beat", 32'(out_q[i]), 32'(exp_q[i]));
        check("pkt_cnt", 32'(pkt_se.size()), 32'(exp_se.size()));
        for (int i = 0; i < pkt_se.size() && i < exp_se.size(); i++)
            check("pkt_se", 32'(pkt_se[i]), 32'(exp_se[i]));
        out_q.delete();
        exp_q.delete();
        pkt_se.delete();
        exp_se.delete();
    endtask

    initial begin
        rst     = 1'b1;
        y_ready = 1'b1;
        a_q = '{9'h011, 9'h022, 9'h133};
        b_q = '{9'h1C0};
        drive();

        // Reset with both channels valid
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_outs", 32'({y_valid, se, en, a_ready, b_ready, err}), 32'd0);
        end
        rst = 1'b0;
        check("rel_idle_en", 32'(en), 32'd0);
        step();
        check("lock_a", 32'({en, se}), 32'b10);

        // Single A packet, then the waiting B packet
        exp_q  = '{9'h011, 9'h022, 9'h133, 9'h1C0};
        exp_se = '{1'b0, 1'b1};
        drain(60);
        cmp_logs();

        // Round robin with both channels continuously loaded
        bubbles = 0;
        a_q = '{9'h0A0, 9'h1A1, 9'h0A0, 9'h1A1};
        b_q = '{9'h0B0, 9'h1B1, 9'h0B0, 9'h1B1};
        drive();
        exp_q  = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
        exp_se = '{1'b0, 1'b1, 1'b0, 1'b1};
        drain(100);
        check("rr_bubbles", 32'(bubbles), 32'd4);
        cmp_logs();

        // Backpressure mid-packet; exactly MAX_BEATS beats with last is a normal end
        a_q = '{9'h001, 9'h002, 9'h003, 9'h104};
        drive();
        wait_y(8'h02, 20);
        y_ready = 1'b0;
        repeat (4) step();
        check("bp_frozen", 32'({y_valid, y_data}), 32'h102);
        y_ready = 1'b1;
        exp_q  = '{9'h001, 9'h002, 9'h003, 9'h104};
        exp_se = '{1'b0};
        drain(60);
        check("bp_no_err", 32'(err_cnt), 32'd0);
        cmp_logs();

        // Overlong A packet forces release after MAX_BEATS beats
        a_q = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h045, 9'h146};
        drive();
        step();
        b_q = '{9'h1B5};
        drive();
        exp_q  = '{9'h041, 9'h042, 9'h043, 9'h144, 9'h1B5, 9'h045, 9'h146};
        exp_se = '{1'b0, 1'b1, 1'b0};
        drain(100);
        check("force_err_cnt", 32'(err_cnt), 32'd1);
        cmp_logs();

        // Reset during beat 2 of a B packet
        b_q = '{9'h0D0, 9'h0D1, 9'h1D2};
        drive();
        wait_y(8'hD1, 20);
        check("pre_rst_se", 32'(se), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst", 32'({y_valid, en, se}), 32'd0);
        rst = 1'b0;
        a_q.delete();
        b_q.delete();
        out_q.delete();
        pkt_se.delete();
        beat_n  = 0;
        new_pkt = 1'b1;
        a_q = '{9'h1E0};
        b_q = '{9'h1F0};
        drive();
        exp_q  = '{9'h1E0, 9'h1F0};
        exp_se = '{1'b0, 1'b1};
        drain(60);
        cmp_logs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
